uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx_pkg.sv | 25 ++
 rtl/uart_rx_fifo.sv | 61 ++++++
 rtl/uart_rx.sv | 206 ++++++++++++++++++++
 tb/tb_uart_rx.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: register map,
// STATUS bit positions and receiver FSM encoding.
package uart_rx_pkg;

  localparam logic [1:0] REG_RXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_DIVISOR = 2'd2;
  localparam logic [1:0] REG_RSVD    = 2'd3;

  localparam int ST_NE   = 0;
  localparam int ST_FULL = 1;
  localparam int ST_OVR  = 2;
  localparam int ST_FRM  = 3;

  localparam int TICKS_PER_BIT = 16;
  localparam int MID_TICK      = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Byte FIFO for received characters; a push is accepted
// while full when a pop happens in the same cycle.
module rx_fifo #(
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, receive FIFO
// and a simple request/ready register interface.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'd26
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rxd,
  input  logic        MRead,
  input  logic        MWrite,
  input  logic        MEnable,
  input  logic [23:0] MAddress,
  input  logic [31:0] MWriteData,
  output logic [31:0] MReadData,
  output logic        MReady,
  output logic        irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  rx_state_e   state_q, state_d;
  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic [1:0]  arm_q, arm_d;
  logic [15:0] div_cnt_q, div_cnt_d;
  logic [15:0] divisor_q, divisor_d;
  logic [3:0]  tick_cnt_q, tick_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        ovr_q, ovr_d;
  logic        frm_q, frm_d;
  logic        mready_q, mready_d;
  logic [31:0] rdata_q, rdata_d;

  logic          tick, start, wr, rd;
  logic [1:0]    sel;
  logic          push, pop;
  logic          ovr_set, frm_set;
  logic [3:0]    status_w;
  logic [7:0]    fifo_dout;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          unused_ok;

  rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (shift_q),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign sel   = MAddress[3:2];
  assign start = MEnable & (MRead | MWrite) & ~mready_q;
  assign wr    = start & MWrite;
  assign rd    = start & MRead & ~MWrite;
  assign pop   = rd & (sel == REG_RXDATA) & ~fifo_empty;
  assign tick  = (div_cnt_q == divisor_q);

  always_comb begin
    status_w         = '0;
    status_w[ST_NE]  = ~fifo_empty;
    status_w[ST_FULL] = fifo_full;
    status_w[ST_OVR] = ovr_q;
    status_w[ST_FRM] = frm_q;
  end

  always_comb begin
    state_d    = state_q;
    sync1_d    = rxd;
    sync2_d    = sync1_q;
    arm_d      = arm_q;
    div_cnt_d  = tick ? 16'd0 : div_cnt_q + 16'd1;
    divisor_d  = divisor_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    mready_d   = start;
    rdata_d    = rdata_q;
    push       = 1'b0;
    ovr_set    = 1'b0;
    frm_set    = 1'b0;

    // Only arm after the synchronizer has flushed and the line was seen idle.
    if (arm_q != 2'd3) begin
      if (arm_q == 2'd2) arm_d = sync2_q ? 2'd3 : 2'd2;
      else               arm_d = arm_q + 2'd1;
    end

    if (start) begin
      rdata_d = '0;
      if (rd) begin
        unique case (sel)
          REG_RXDATA:  rdata_d = {24'd0, fifo_empty ? 8'd0 : fifo_dout};
          REG_STATUS:  rdata_d = {28'd0, status_w};
          REG_DIVISOR: rdata_d = {16'd0, divisor_q};
          REG_RSVD:    rdata_d = '0;
        endcase
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (arm_q == 2'd3 && !sync2_q) begin
          state_d    = S_START;
          tick_cnt_d = '0;
          div_cnt_d  = '0;
        end
      end
      S_START: begin
        if (tick) begin
          if (tick_cnt_q == 4'(MID_TICK - 1)) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            state_d    = sync2_q ? S_IDLE : S_DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'(TICKS_PER_BIT - 1)) begin
            shift_d   = {sync2_q, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_d = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'(TICKS_PER_BIT - 1)) begin
            state_d = S_IDLE;
            if (!sync2_q)                frm_set = 1'b1;
            else if (fifo_full && !pop)  ovr_set = 1'b1;
            else                         push    = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (wr && sel == REG_DIVISOR) begin
      divisor_d = MWriteData[15:0];
      div_cnt_d = '0;
    end

    ovr_d = ovr_q;
    frm_d = frm_q;
    if (wr && sel == REG_STATUS) begin
      if (MWriteData[ST_OVR]) ovr_d = 1'b0;
      if (MWriteData[ST_FRM]) frm_d = 1'b0;
    end
    if (ovr_set) ovr_d = 1'b1;
    if (frm_set) frm_d = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      arm_q      <= '0;
      div_cnt_q  <= '0;
      divisor_q  <= DIV_RESET;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      ovr_q      <= 1'b0;
      frm_q      <= 1'b0;
      mready_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      arm_q      <= arm_d;
      div_cnt_q  <= div_cnt_d;
      divisor_q  <= divisor_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      ovr_q      <= ovr_d;
      frm_q      <= frm_d;
      mready_q   <= mready_d;
      rdata_q    <= rdata_d;
    end
  end

  assign MReady    = mready_q;
  assign MReadData = rdata_q;
  assign irq       = ~fifo_empty | ovr_q | frm_q;

  assign unused_ok = ^{MAddress[23:4], MAddress[1:0],
                       MWriteData[31:16], fifo_count};

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: vector table, directed
// corner sequences and randomized frames against a queue model.
module tb_uart_rx;

  logic        clock = 1'b0;
  logic        reset;
  logic        rxd;
  logic        MRead, MWrite, MEnable;
  logic [23:0] MAddress;
  logic [31:0] MWriteData;
  logic [31:0] MReadData;
  logic        MReady;
  logic        irq;

  always #5 clock = ~clock;

  uart_rx dut (
    .clock      (clock),
    .reset      (reset),
    .rxd        (rxd),
    .MRead      (MRead),
    .MWrite     (MWrite),
    .MEnable    (MEnable),
    .MAddress   (MAddress),
    .MWriteData (MWriteData),
    .MReadData  (MReadData),
    .MReady     (MReady),
    .irq        (irq)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int bit_clks = 16;

  logic [7:0] mq[$];
  logic       m_ovr, m_frm;

  typedef struct {
    logic [7:0] b;
    logic       stop;
    logic [3:0] st_exp;
    logic [7:0] rd_exp;
    logic [3:0] st_after;
    logic       clr;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
  endtask

  task automatic bus(input logic wr, input logic [3:0] a,
                     input logic [31:0] wd, output logic [31:0] rdv);
    @(negedge clock);
    MEnable = 1'b1; MWrite = wr; MRead = ~wr;
    MAddress = {20'd0, a}; MWriteData = wd;
    @(negedge clock);
    MEnable = 1'b0; MRead = 1'b0; MWrite = 1'b0;
    rdv = MReadData;
    if (MReady !== 1'b1) chk("mready_pulse", {31'd0, MReady}, 32'd1);
    @(negedge clock);
    if (MReady !== 1'b0) chk("mready_single", {31'd0, MReady}, 32'd0);
  endtask

  task automatic rd_chk(input string nm, input logic [3:0] a,
                        input logic [31:0] exp);
    logic [31:0] v;
    bus(1'b0, a, 32'd0, v);
    chk(nm, v, exp);
  endtask

  task automatic wr_reg(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] v;
    bus(1'b1, a, d, v);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clock);
    rxd = 1'b0;
    repeat (bit_clks) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (bit_clks) @(negedge clock);
    end
    rxd = stop;
    repeat (bit_clks) @(negedge clock);
    rxd = 1'b1;
    repeat (20) @(negedge clock);
  endtask

  function automatic logic [31:0] m_status();
    return {28'd0, m_frm, m_ovr, mq.size() == 4, mq.size() != 0};
  endfunction

  task automatic m_frame(input logic [7:0] b, input logic stop);
    if (!stop)              m_frm = 1'b1;
    else if (mq.size() < 4) mq.push_back(b);
    else                    m_ovr = 1'b1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    logic [7:0]  rb, exp8;
    logic        sb;

    vt[0] = '{8'hA5, 1'b1, 4'h1, 8'hA5, 4'h0, 1'b0};
    vt[1] = '{8'h3C, 1'b0, 4'h8, 8'h00, 4'h8, 1'b0};
    vt[2] = '{8'h5A, 1'b1, 4'h9, 8'h5A, 4'h8, 1'b1};
    vt[3] = '{8'hFF, 1'b1, 4'h1, 8'hFF, 4'h0, 1'b0};
    vt[4] = '{8'h00, 1'b1, 4'h1, 8'h00, 4'h0, 1'b0};
    vt[5] = '{8'h81, 1'b1, 4'h1, 8'h81, 4'h0, 1'b0};

    rxd = 1'b1; MRead = 1'b0; MWrite = 1'b0; MEnable = 1'b0;
    MAddress = '0; MWriteData = '0;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_mready", {31'd0, MReady}, 32'd0);
    chk("rst_rdata", MReadData, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    rd_chk("rst_status", 4'h4, 32'd0);
    rd_chk("rst_divisor", 4'h8, 32'd26);
    rd_chk("rsvd_read", 4'hC, 32'd0);
    bus(1'b1, 4'hC, 32'hFFFF_FFFF, v);
    chk("wr_rdata_zero", v, 32'd0);
    wr_reg(4'h8, 32'h0000_1234);
    rd_chk("divisor_rw", 4'h8, 32'h1234);
    rd_chk("empty_rxdata", 4'h0, 32'd0);
    wr_reg(4'h8, 32'd0);

    for (int i = 0; i < 6; i++) begin
      send_byte(vt[i].b, vt[i].stop);
      rd_chk($sformatf("vec%0d_status", i), 4'h4, {28'd0, vt[i].st_exp});
      chk($sformatf("vec%0d_irq", i), {31'd0, irq},
          {31'd0, vt[i].st_exp != 4'h0});
      rd_chk($sformatf("vec%0d_data", i), 4'h0, {24'd0, vt[i].rd_exp});
      rd_chk($sformatf("vec%0d_after", i), 4'h4, {28'd0, vt[i].st_after});
      if (vt[i].clr) begin
        wr_reg(4'h4, 32'hC);
        rd_chk($sformatf("vec%0d_clr", i), 4'h4, 32'd0);
      end
    end
    chk("irq_idle", {31'd0, irq}, 32'd0);

    // Slower divisor: 32 clocks per bit.
    wr_reg(4'h8, 32'd1);
    bit_clks = 32;
    send_byte(8'hC3, 1'b1);
    rd_chk("div1_data", 4'h0, 32'hC3);
    wr_reg(4'h8, 32'd0);
    bit_clks = 16;

    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
    rd_chk("ovr_status", 4'h4, 32'h7);
    for (int i = 1; i <= 4; i++)
      rd_chk($sformatf("ovr_data%0d", i), 4'h0, 32'(i));
    rd_chk("ovr_empty_read", 4'h0, 32'd0);
    wr_reg(4'h4, 32'h4);
    rd_chk("ovr_cleared", 4'h4, 32'd0);

    @(negedge clock);
    rxd = 1'b0;
    repeat (4) @(negedge clock);
    rxd = 1'b1;
    repeat (40) @(negedge clock);
    rd_chk("glitch_status", 4'h4, 32'd0);
    send_byte(8'h6E, 1'b1);
    rd_chk("post_glitch_data", 4'h0, 32'h6E);

    for (int i = 0; i < 4; i++) send_byte(8'(8'h11 + i), 1'b1);
    fork
      send_byte(8'h15, 1'b1);
      begin
        logic [31:0] pv;
        repeat (154) @(negedge clock);
        bus(1'b0, 4'h0, 32'd0, pv);
        chk("sim_pop_data", pv, 32'h11);
      end
    join
    rd_chk("sim_status", 4'h4, 32'h3);
    for (int i = 0; i < 4; i++)
      rd_chk($sformatf("sim_data%0d", i), 4'h0, 32'(8'h12 + i));
    rd_chk("sim_drained", 4'h4, 32'd0);

    send_byte(8'h77, 1'b1);
    fork
      send_byte(8'h00, 1'b1);
      begin
        repeat (71) @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
      end
    join
    rd_chk("mid_rst_divisor", 4'h8, 32'd26);
    rd_chk("mid_rst_status", 4'h4, 32'd0);
    wr_reg(4'h8, 32'd0);
    send_byte(8'h96, 1'b1);
    rd_chk("mid_rst_st1", 4'h4, 32'h1);
    rd_chk("mid_rst_data", 4'h0, 32'h96);
    rd_chk("mid_rst_st0", 4'h4, 32'd0);

    mq.delete();
    m_ovr = 1'b0;
    m_frm = 1'b0;
    for (int it = 0; it < 16; it++) begin
      rb = 8'($urandom);
      sb = ($urandom_range(0, 3) != 0);
      send_byte(rb, sb);
      m_frame(rb, sb);
      for (int r = 0; r < int'($urandom_range(0, 2)); r++) begin
        exp8 = (mq.size() != 0) ? mq.pop_front() : 8'd0;
        rd_chk($sformatf("rnd%0d_data", it), 4'h0, {24'd0, exp8});
      end
      rd_chk($sformatf("rnd%0d_status", it), 4'h4, m_status());
      chk($sformatf("rnd%0d_irq", it), {31'd0, irq},
          {31'd0, m_status() != 32'd0});
      if ($urandom_range(0, 2) == 0) begin
        wr_reg(4'h4, 32'hC);
        m_ovr = 1'b0;
        m_frm = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
